// File: rtl/warp_pkg.sv
// Shared definitions for the warp/decay pixel pipeline: pixel and address
// widths, the WISHBONE byte-select used by the reader and the writer, and
// the word-to-byte address conversion.
package warp_pkg;

  localparam int PIX_W      = 24;
  localparam int ADDR_W     = 30;
  localparam int ADDR_SHIFT = 2;

  // Only the low three byte lanes carry pixel data.
  localparam logic [3:0] WB_SEL = 4'b0111;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [ADDR_W-1:0] waddr_t;

  // Word addresses become byte addresses on the bus by appending zero bits.
  function automatic logic [31:0] wordToByte(input waddr_t a);
    return {a, {ADDR_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/readsrc_fifo.sv
// Small synchronous FIFO with a combinational head read. Storage has no
// reset; only the pointers and the occupancy count are cleared.
module readsrc_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             doPush;
  logic             doPop;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CW'(DEPTH));
  assign count_o     = count_q;
  assign head_data_o = mem_q[head_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign doPop  = pop_i & ~empty_o;
  assign doPush = push_i & (~full_o | doPop);

  // Occupancy moves by one unless a push and a pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (doPush) tail_q <= tail_q + 1'b1;
      if (doPop)  head_q <= head_q + 1'b1;
    end
  end

  // Entry storage is written at the tail; its contents after reset are irrelevant.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[tail_q] <= push_data_i;
  end

endmodule

// File: rtl/readsrc.sv
// Source-pixel reader: turns a stream of word addresses into single-beat
// WISHBONE reads (one outstanding at a time) and hands the returned pixels
// downstream through a small FIFO, strictly in request order.
// Optional build macro READSRC_TAG_EN adds s_tag/p_tag, a 30-bit tag that
// travels with each request and comes out alongside its pixel.
module readsrc
  import warp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic              s_ready,
  output logic              s_next,
  output logic [31:0]       mwb_adr_o,
  output logic              mwb_stb_o,
  input  logic              mwb_ack_i,
  input  logic [31:0]       mwb_dat_i,
  output logic [3:0]        mwb_sel_o,
  output logic [PIX_W-1:0]  p_data,
  output logic              p_ready,
  input  logic              p_next
`ifdef READSRC_TAG_EN
  ,
  input  logic [ADDR_W-1:0] s_tag,
  output logic [ADDR_W-1:0] p_tag
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
`ifdef READSRC_TAG_EN
  localparam int FW = PIX_W + ADDR_W;
`else
  localparam int FW = PIX_W;
`endif

  logic          stb_q, stb_d;
  logic [31:0]   adr_q, adr_d;
  logic [CW-1:0] fifoCount;
  logic          fifoEmpty;
  logic          fifoFullUnused;
  logic [FW-1:0] fifoIn;
  logic [FW-1:0] fifoHead;
  logic          ackValid;
  logic          reqAccept;
  logic          slotAvail;
  logic          unusedDatHi;

`ifdef READSRC_TAG_EN
  logic [ADDR_W-1:0] tag_q, tag_d;
`endif

  assign mwb_stb_o = stb_q;
  assign mwb_adr_o = adr_q;
  assign mwb_sel_o = WB_SEL;

  // Only an ack for our own outstanding strobe counts.
  assign ackValid = mwb_ack_i & stb_q;

  // Reserve a slot for the in-flight read as well, so every read has somewhere
  // to land. Uses the registered count only, keeping p_next out of this path.
  assign slotAvail = (int'(fifoCount) + int'(stb_q)) < DEPTH;
  assign s_next    = (~stb_q | mwb_ack_i) & slotAvail;
  assign reqAccept = s_ready & s_next;

  assign unusedDatHi = ^mwb_dat_i[31:PIX_W];

  // Next request state: a new accept wins over the ack so reads run back-to-back.
  always_comb begin
    stb_d = stb_q;
    adr_d = adr_q;
`ifdef READSRC_TAG_EN
    tag_d = tag_q;
`endif
    if (reqAccept) begin
      stb_d = 1'b1;
      adr_d = wordToByte(s_addr);
`ifdef READSRC_TAG_EN
      tag_d = s_tag;
`endif
    end else if (ackValid) begin
      stb_d = 1'b0;
    end
  end

  // Request registers; reset drops the strobe and abandons any outstanding read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_q <= 1'b0;
      adr_q <= '0;
`ifdef READSRC_TAG_EN
      tag_q <= '0;
`endif
    end else begin
      stb_q <= stb_d;
      adr_q <= adr_d;
`ifdef READSRC_TAG_EN
      tag_q <= tag_d;
`endif
    end
  end

`ifdef READSRC_TAG_EN
  assign fifoIn = {tag_q, mwb_dat_i[PIX_W-1:0]};
  assign p_tag  = fifoHead[FW-1:PIX_W];
`else
  assign fifoIn = mwb_dat_i[PIX_W-1:0];
`endif

  assign p_data  = fifoHead[PIX_W-1:0];
  assign p_ready = ~fifoEmpty;

  readsrc_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ackValid),
    .push_data_i (fifoIn),
    .pop_i       (p_ready & p_next),
    .head_data_o (fifoHead),
    .count_o     (fifoCount),
    .empty_o     (fifoEmpty),
    .full_o      (fifoFullUnused)
  );

endmodule

// File: tb/tb_readsrc.sv
// Scoreboard bench for readsrc: stimulus queues expected addresses, tags and
// pixels; a negedge monitor pops and compares on every bus ack and pixel pop.
module tb_readsrc;
  import warp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] s_addr = '0;
  logic        s_ready = 1'b0;
  logic        s_next;
  logic [31:0] mwb_adr_o;
  logic        mwb_stb_o;
  logic        mwb_ack_i = 1'b0;
  logic [31:0] mwb_dat_i = '0;
  logic [3:0]  mwb_sel_o;
  logic [23:0] p_data;
  logic        p_ready;
  logic        p_next = 1'b0;
  logic [29:0] s_tag = '0;
  logic [29:0] p_tag;

  int errors = 0;
  int checks = 0;

  logic [23:0] pixQ [$];
  logic [31:0] adrQ [$];
  logic [29:0] tagQ [$];

  readsrc #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_addr    (s_addr),
    .s_ready   (s_ready),
    .s_next    (s_next),
    .mwb_adr_o (mwb_adr_o),
    .mwb_stb_o (mwb_stb_o),
    .mwb_ack_i (mwb_ack_i),
    .mwb_dat_i (mwb_dat_i),
    .mwb_sel_o (mwb_sel_o),
    .p_data    (p_data),
    .p_ready   (p_ready),
    .p_next    (p_next)
`ifdef READSRC_TAG_EN
    ,
    .s_tag     (s_tag),
    .p_tag     (p_tag)
`endif
  );

`ifndef READSRC_TAG_EN
  assign p_tag = '0;
`endif

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one request; its byte address and tag are queued in request order.
  task automatic applyStimulus(input logic [29:0] addr, input logic [31:0] byteAddr);
    s_ready = 1'b1;
    s_addr  = addr;
    s_tag   = ~addr;
    adrQ.push_back(byteAddr);
    tagQ.push_back(~addr);
  endtask

  task automatic driveAck(input logic [31:0] data, input logic [23:0] expPix);
    mwb_ack_i = 1'b1;
    mwb_dat_i = data;
    pixQ.push_back(expPix);
  endtask

  task automatic singleRead(input logic [29:0] addr, input logic [31:0] byteAddr,
                            input logic [31:0] data, input logic [23:0] expPix);
    applyStimulus(addr, byteAddr);
    #1;
    checkOutput("single s_next", 32'(s_next), 32'd1);
    cycle();
    s_ready = 1'b0;
    checkOutput("single stb", 32'(mwb_stb_o), 32'd1);
    checkOutput("single adr", mwb_adr_o, byteAddr);
    checkOutput("single sel", 32'(mwb_sel_o), 32'h7);
    cycle();
    checkOutput("single adr held", mwb_adr_o, byteAddr);
    cycle();
    checkOutput("single stb held", 32'(mwb_stb_o), 32'd1);
    driveAck(data, expPix);
    cycle();
    mwb_ack_i = 1'b0;
    checkOutput("single stb drop", 32'(mwb_stb_o), 32'd0);
    checkOutput("single p_ready", 32'(p_ready), 32'd1);
    checkOutput("single p_data", 32'(p_data), 32'(expPix));
`ifdef READSRC_TAG_EN
    checkOutput("single p_tag", 32'(p_tag), 32'(~addr));
`endif
    p_next = 1'b1;
    cycle();
    p_next = 1'b0;
    checkOutput("single drained", 32'(p_ready), 32'd0);
  endtask

  // Monitor: compares bus address on every ack and pixel/tag on every pop.
  always @(negedge clk) begin
    if (!rst) begin
      if (mwb_stb_o && mwb_ack_i) begin
        if (adrQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected ack: adr %h, none expected", mwb_adr_o);
        end else begin
          checkOutput("mon adr", mwb_adr_o, adrQ.pop_front());
        end
      end
      if (p_ready && p_next) begin
        if (pixQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected pixel: got %h, none expected", p_data);
        end else begin
          checkOutput("mon pixel", 32'(p_data), 32'(pixQ.pop_front()));
`ifdef READSRC_TAG_EN
          checkOutput("mon tag", 32'(p_tag), 32'(tagQ.pop_front()));
`else
          void'(tagQ.pop_front());
`endif
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int issued;
    logic [31:0] b2bAdr [3];
    logic [23:0] b2bPix [3];
    b2bAdr = '{32'h4, 32'h8, 32'hC};
    b2bPix = '{24'h0000A1, 24'h0000A2, 24'h0000A3};

    // Reset state
    #2;
    checkOutput("reset stb", 32'(mwb_stb_o), 32'd0);
    checkOutput("reset adr", mwb_adr_o, 32'h0);
    checkOutput("reset p_ready", 32'(p_ready), 32'd0);
    checkOutput("reset s_next", 32'(s_next), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    $display("[TB] single read");
    singleRead(30'h0000100, 32'h00000400, 32'hAB123456, 24'h123456);

    $display("[TB] back-to-back");
    applyStimulus(30'd1, 32'h4);
    cycle();
    checkOutput("b2b stb0", 32'(mwb_stb_o), 32'd1);
    checkOutput("b2b adr0", mwb_adr_o, b2bAdr[0]);
    for (int i = 0; i < 3; i++) begin
      driveAck({8'hFF, b2bPix[i]}, b2bPix[i]);
      if (i < 2) applyStimulus(30'(i + 2), b2bAdr[i+1]);
      else s_ready = 1'b0;
      cycle();
      if (i < 2) begin
        checkOutput("b2b stb", 32'(mwb_stb_o), 32'd1);
        checkOutput("b2b adr", mwb_adr_o, b2bAdr[i+1]);
      end else begin
        checkOutput("b2b stb end", 32'(mwb_stb_o), 32'd0);
      end
    end
    mwb_ack_i = 1'b0;
    p_next = 1'b1;
    repeat (3) cycle();
    p_next = 1'b0;
    checkOutput("b2b drained", 32'(p_ready), 32'd0);

    $display("[TB] backpressure");
    issued = 0;
    for (int i = 0; i < 8; i++) begin
      mwb_ack_i = 1'b0;
      s_ready = 1'b1;
      s_addr  = 30'h20 + 30'(issued);
      s_tag   = ~s_addr;
      if (mwb_stb_o) driveAck(32'h00B00000 + 32'(i), 24'hB00000 + 24'(i));
      #1;
      if (s_next) begin
        adrQ.push_back({s_addr, 2'b00});
        tagQ.push_back(~s_addr);
        issued++;
      end
      cycle();
    end
    mwb_ack_i = 1'b0;
    checkOutput("bp reads", 32'(issued), 32'd4);
    checkOutput("bp s_next", 32'(s_next), 32'd0);
    checkOutput("bp stb", 32'(mwb_stb_o), 32'd0);
    checkOutput("bp p_ready", 32'(p_ready), 32'd1);
    p_next = 1'b1;
    #1;
    checkOutput("bp s_next no comb path", 32'(s_next), 32'd0);
    cycle();
    p_next = 1'b0;
    issued = 0;
    for (int i = 0; i < 6; i++) begin
      mwb_ack_i = 1'b0;
      s_addr = 30'h30 + 30'(issued);
      s_tag  = ~s_addr;
      if (mwb_stb_o) driveAck(32'h00C00000 + 32'(i), 24'hC00000 + 24'(i));
      #1;
      if (s_next) begin
        adrQ.push_back({s_addr, 2'b00});
        tagQ.push_back(~s_addr);
        issued++;
      end
      cycle();
    end
    mwb_ack_i = 1'b0;
    s_ready = 1'b0;
    checkOutput("bp refill reads", 32'(issued), 32'd1);
    checkOutput("bp refill stb", 32'(mwb_stb_o), 32'd0);
    checkOutput("bp refill s_next", 32'(s_next), 32'd0);
    p_next = 1'b1;
    repeat (4) cycle();
    p_next = 1'b0;
    checkOutput("bp drained", 32'(p_ready), 32'd0);

    $display("[TB] simultaneous push/pop");
    applyStimulus(30'h40, 32'h100);
    cycle();
    driveAck(32'h00D10001, 24'hD10001);
    applyStimulus(30'h41, 32'h104);
    cycle();
    driveAck(32'h00D20002, 24'hD20002);
    applyStimulus(30'h42, 32'h108);
    cycle();
    mwb_ack_i = 1'b0;
    s_ready = 1'b0;
    checkOutput("pp stb", 32'(mwb_stb_o), 32'd1);
    checkOutput("pp head", 32'(p_data), 32'h00D10001);
    driveAck(32'h00D30003, 24'hD30003);
    p_next = 1'b1;
    cycle();
    mwb_ack_i = 1'b0;
    p_next = 1'b0;
    checkOutput("pp stb drop", 32'(mwb_stb_o), 32'd0);
    checkOutput("pp new head", 32'(p_data), 32'h00D20002);
    p_next = 1'b1;
    cycle();
    checkOutput("pp count after pop", 32'(p_ready), 32'd1);
    cycle();
    p_next = 1'b0;
    checkOutput("pp drained", 32'(p_ready), 32'd0);

    $display("[TB] spurious ack");
    mwb_ack_i = 1'b1;
    mwb_dat_i = 32'hDEADBEEF;
    cycle();
    mwb_ack_i = 1'b0;
    checkOutput("spur empty p_ready", 32'(p_ready), 32'd0);
    applyStimulus(30'h50, 32'h140);
    cycle();
    s_ready = 1'b0;
    driveAck(32'h00E50005, 24'hE50005);
    cycle();
    mwb_ack_i = 1'b1;
    mwb_dat_i = 32'hDEADBEEF;
    cycle();
    mwb_ack_i = 1'b0;
    checkOutput("spur p_ready", 32'(p_ready), 32'd1);
    checkOutput("spur p_data", 32'(p_data), 32'h00E50005);
    p_next = 1'b1;
    cycle();
    p_next = 1'b0;
    checkOutput("spur no push", 32'(p_ready), 32'd0);

    $display("[TB] async reset mid-read");
    applyStimulus(30'h60, 32'h180);
    cycle();
    driveAck(32'h00F10001, 24'hF10001);
    applyStimulus(30'h61, 32'h184);
    cycle();
    driveAck(32'h00F20002, 24'hF20002);
    applyStimulus(30'h62, 32'h188);
    cycle();
    driveAck(32'h00F30003, 24'hF30003);
    applyStimulus(30'h63, 32'h18C);
    cycle();
    mwb_ack_i = 1'b0;
    s_ready = 1'b0;
    checkOutput("rst pre stb", 32'(mwb_stb_o), 32'd1);
    checkOutput("rst pre s_next", 32'(s_next), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst async stb", 32'(mwb_stb_o), 32'd0);
    checkOutput("rst async p_ready", 32'(p_ready), 32'd0);
    checkOutput("rst async adr", mwb_adr_o, 32'h0);
    checkOutput("rst async s_next", 32'(s_next), 32'd1);
    pixQ.delete();
    adrQ.delete();
    tagQ.delete();
    @(negedge clk);
    rst = 1'b0;
    cycle();
    singleRead(30'h0000100, 32'h00000400, 32'hAB123456, 24'h123456);

    checkOutput("scoreboard pixels left", 32'(pixQ.size()), 32'd0);
    checkOutput("scoreboard addrs left", 32'(adrQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/readsrc.md
Name: readsrc

Overview:
- WISHBONE read-only master that fetches source pixels for the warp/decay pipeline; the read-side counterpart of the destination-pixel writer.
- Accepts a stream of 30-bit word addresses and issues single-beat WISHBONE reads.
- Buffers returned 24-bit pixels in a small FIFO and presents them downstream with the pipeline's ready/next handshake.
- Sits between the source-coordinate generator and the interpolation/decay stage.

Parameters:
- DEPTH, 4, output FIFO entries. Power of two, ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- s_addr  in  30  source pixel word address
- s_ready  in  1  s_addr valid
- s_next  out  1  block accepts s_addr this cycle
- mwb_adr_o  out  32  WISHBONE address, {s_addr,2'b00}
- mwb_stb_o  out  1  read strobe; implies read (no WE)
- mwb_ack_i  in  1  slave acknowledge
- mwb_dat_i  in  32  read data; bits [23:0] used
- mwb_sel_o  out  4  constant 4'b0111
- p_data  out  24  pixel at FIFO head
- p_ready  out  1  p_data valid
- p_next  in  1  consumer takes p_data this cycle

Behaviour:
- Handshakes: a request transfers when s_ready & s_next; a pixel transfers when p_ready & p_next.
- Reset (async): mwb_adr_o=0, mwb_stb_o=0, FIFO count/pointers=0, p_ready=0, storage don't-care. Reset mid-cycle drops stb immediately, abandons the outstanding read and flushes the FIFO.
- One outstanding read maximum. stb is held with a stable address until ack.
- s_next = (~mwb_stb_o | mwb_ack_i) & (count + mwb_stb_o < DEPTH).
  - Registered count only; no combinational path from p_next to s_next.
  - Guarantees a FIFO slot for every issued read.
- Request accept (s_ready & s_next): mwb_adr_o <= {s_addr,2'b00}, mwb_stb_o <= 1 next cycle.
- Ack while stb:
  - mwb_dat_i[23:0] is pushed into the FIFO at the tail.
  - If a new request is accepted the same cycle, stb stays 1 with the new address (back-to-back, no idle cycle); otherwise stb <= 0.
- Ack while ~stb: ignored, no push.
- Latency: stb asserted 1 cycle after accept; p_ready asserted 1 cycle after the ack cycle (pixel registered into FIFO).
- FIFO:
  - count in [0,DEPTH], width clog2(DEPTH+1).
  - Head/tail pointers of log2(DEPTH) bits wrap naturally.
  - p_ready = (count != 0); p_data = storage[head], combinational read.
  - Pop on p_ready & p_next; pop on empty is impossible by construction.
  - Simultaneous push and pop: count unchanged, both pointers advance. Full plus pop without push: count-1.
- Ordering: pixels are delivered strictly in request order.
- Full FIFO with consumer stalled: s_next=0, stb deasserts after the last ack, no further reads issued.

Optional Feature:
- READSRC_TAG_EN: adds ports s_tag in 30 and p_tag out 30.
  - s_tag is captured with s_addr on accept, held alongside the outstanding read, and pushed into the FIFO with the pixel.
  - p_tag is the head entry's tag, valid with p_ready; it carries the destination address through to the writer.
  - Reset value of the captured tag register is 0.
- Without the macro: no tag ports or storage; behaviour is otherwise identical.

Decomposition:
- Shared package/header (warp_pkg) holds:
  - Pixel width constant (24) and address width constant (30).
  - Byte-select constant 4'b0111, shared with the writer.
  - Word-to-byte address shift (2).
- Sub-module readsrc_fifo (parameters WIDTH, DEPTH): push/pop, count, data out, empty/full.
  - Instantiated with WIDTH=24, or 54 under READSRC_TAG_EN.

Test Plan:
- Single read: s_addr=30'h0000100, s_ready 1 cycle → next cycle mwb_adr_o=32'h00000400, stb=1. Slave acks 2 cycles later with dat 32'hAB123456 → next cycle p_ready=1, p_data=24'h123456, stb=0.
- Back-to-back: s_ready held with addrs 1,2,3 and ack every cycle → stb stays high continuously, addrs 4,8,C on consecutive cycles; p_data sequence matches input order.
- Backpressure: p_next=0 and DEPTH=4 → exactly 4 reads issued, then s_next=0 and stb=0. Assert p_next for 1 cycle → one pop and exactly one new read issued.
- Simultaneous push/pop: FIFO at count=2, ack and p_next in the same cycle → count stays 2 and the correct head pixel is popped.
- Spurious ack: mwb_ack_i=1 with stb=0 → no FIFO change, p_ready unchanged.
- Async reset mid-read: assert rst while stb=1 and count=3 → stb, p_ready and count drop to 0 without waiting for a clock edge. After release the first new request behaves as the single-read case (tag also checked under READSRC_TAG_EN).
